rf_write_arbiter: RTL and testbench

Shares the single register-file write port (we/wa/wd) between two writeback requesters: port 0 (ALU result) and port 1 (memory load). Each port has a valid/ready handshake and a one-entry holding buffer. A per-cycle arbiter drains the buffers into a registered write port, and a pending-write mask is exported for hazard/stall logic. Sits between the execute/memory stages and the register file write inputs.

---
 rtl/rf_pkg.sv | 23 ++
 rtl/rf_write_arbiter_buf.sv | 33 +++
 rtl/rf_write_arbiter.sv | 111 +++++++++++
 tb/tb_rf_write_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and sizes for the register-file write arbiter.
// Optional feature macro: RF_WRITE_ARB_RR_EN (round-robin conflict policy).
package rf_pkg;

  localparam int RF_AW   = 5;
  localparam int RF_DW   = 32;
  localparam int RF_NREG = 32;

  typedef struct packed {
    logic [RF_AW-1:0] addr;
    logic [RF_DW-1:0] data;
  } rf_wr_t;

  // One-hot register select; register 0 never reports pending.
  function automatic logic [RF_NREG-1:0] rf_dec(input logic [RF_AW-1:0] a);
    logic [RF_NREG-1:0] m;
    m    = '0;
    m[a] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_buf.sv
// One-entry valid/ready holding register for a writeback requester.
// Writes to register 0 are accepted but never stored.
module rf_wr_buf
  import rf_pkg::*;
(
  input  logic   clk,
  input  logic   reset_b,
  input  logic   in_valid,
  input  rf_wr_t in_wr,
  input  logic   drain,
  output logic   ready,
  output logic   full,
  output logic   load,
  output rf_wr_t wr
);

  // Ready depends on state (full, drain) and reset only, never on in_valid.
  assign ready = ~reset_b & (~full | drain);
  assign load  = in_valid & ready & (in_wr.addr != '0);

  always_ff @(posedge clk) begin
    if (reset_b) begin
      full <= 1'b0;
      wr   <= '0;
    end else if (load) begin
      full <= 1'b1;
      wr   <= in_wr;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Two-port writeback arbiter driving a single registered register-file write port.
// Define RF_WRITE_ARB_RR_EN for round-robin on different-address conflicts;
// otherwise port 1 (load) has fixed priority.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic          p0_valid,
  output logic          p0_ready,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_data,
  input  logic          p1_valid,
  output logic          p1_ready,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_data,
  output logic          rf_we,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd,
  output logic [31:0]   pend_mask
);

  rf_wr_t in0, in1, wr0, wr1, out_q;
  logic   full0, full1, load0, load1;
  logic   gnt0, gnt1;
  logic   both, same;
  logic   older1;   // 1: buffer 1 holds the older entry
  logic   we_q;

  assign in0 = '{addr: p0_addr, data: p0_data};
  assign in1 = '{addr: p1_addr, data: p1_data};

  rf_wr_buf u_buf0 (
    .clk(clk), .reset_b(reset_b), .in_valid(p0_valid), .in_wr(in0),
    .drain(gnt0), .ready(p0_ready), .full(full0), .load(load0), .wr(wr0)
  );

  rf_wr_buf u_buf1 (
    .clk(clk), .reset_b(reset_b), .in_valid(p1_valid), .in_wr(in1),
    .drain(gnt1), .ready(p1_ready), .full(full1), .load(load1), .wr(wr1)
  );

  assign both = full0 & full1;
  assign same = (wr0.addr == wr1.addr);

`ifdef RF_WRITE_ARB_RR_EN
  logic last1;      // port granted on the last different-address conflict

  always_ff @(posedge clk) begin
    if (reset_b)          last1 <= 1'b0;
    else if (both & ~same) last1 <= gnt1;
  end
`endif

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (both) begin
      if (same) begin
        gnt1 = older1;
        gnt0 = ~older1;
      end else begin
`ifdef RF_WRITE_ARB_RR_EN
        gnt1 = ~last1;
        gnt0 = last1;
`else
        gnt1 = 1'b1;
`endif
      end
    end else begin
      gnt0 = full0;
      gnt1 = full1;
    end
  end

  // A freshly loaded entry is younger than whatever the other buffer keeps;
  // same-edge loads make port 0 the older one.
  always_ff @(posedge clk) begin
    if (reset_b)             older1 <= 1'b0;
    else if (load0 & load1)  older1 <= 1'b0;
    else if (load0)          older1 <= 1'b1;
    else if (load1)          older1 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset_b) begin
      we_q  <= 1'b0;
      out_q <= '0;
    end else if (gnt0 | gnt1) begin
      we_q  <= 1'b1;
      out_q <= gnt1 ? wr1 : wr0;
    end else begin
      we_q  <= 1'b0;
    end
  end

  assign rf_we = we_q;
  assign rf_wa = out_q.addr;
  assign rf_wd = out_q.data;

  always_comb begin
    pend_mask = '0;
    if (full0) pend_mask = pend_mask | rf_dec(wr0.addr);
    if (full1) pend_mask = pend_mask | rf_dec(wr1.addr);
    if (we_q)  pend_mask = pend_mask | rf_dec(out_q.addr);
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized + directed bench for rf_write_arbiter against a queue-style reference model.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_valid, p1_valid;
  logic        p0_ready, p1_ready;
  logic [4:0]  p0_addr, p1_addr;
  logic [31:0] p0_data, p1_data;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] pend_mask;

  always #5 clk = ~clk;

  rf_write_arbiter #(.AW(5), .DW(32)) dut (
    .clk(clk), .reset_b(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr), .p0_data(p0_data),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_data(p1_data),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .pend_mask(pend_mask)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each port holds at most one pending write tagged with its
  // acceptance stamp; the write port shows the last issued write.
  logic        m_full[2];
  logic [4:0]  m_addr[2];
  logic [31:0] m_data[2];
  int          m_stamp[2];
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  int          m_last;
  int          cyc = 0;
  logic        acc0, acc1;
  logic [31:0] shadow[32];

  function automatic int pick();
    if (!m_full[0] && !m_full[1]) return -1;
    if (!m_full[1]) return 0;
    if (!m_full[0]) return 1;
    if (m_addr[0] == m_addr[1]) return (m_stamp[0] < m_stamp[1]) ? 0 : 1;
`ifdef RF_WRITE_ARB_RR_EN
    return 1 - m_last;
`else
    return 1;
`endif
  endfunction

  task automatic cycle();
    int g;
    logic r0, r1;
    logic [31:0] pm;
    #1;
    g  = pick();
    r0 = !rst && (!m_full[0] || g == 0);
    r1 = !rst && (!m_full[1] || g == 1);
    chk("p0_ready", p0_ready, r0);
    chk("p1_ready", p1_ready, r1);
    acc0 = p0_valid && r0;
    acc1 = p1_valid && r1;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_full[0] = 0; m_full[1] = 0;
      m_we = 0; m_wa = 0; m_wd = 0; m_last = 0;
    end else begin
      if (g >= 0) begin
        if (m_full[0] && m_full[1] && m_addr[0] != m_addr[1]) m_last = g;
        m_we = 1; m_wa = m_addr[g]; m_wd = m_data[g];
        m_full[g] = 0;
      end else begin
        m_we = 0;
      end
      if (acc0 && p0_addr != 0) begin
        m_full[0] = 1; m_addr[0] = p0_addr; m_data[0] = p0_data; m_stamp[0] = cyc * 2;
      end
      if (acc1 && p1_addr != 0) begin
        m_full[1] = 1; m_addr[1] = p1_addr; m_data[1] = p1_data; m_stamp[1] = cyc * 2 + 1;
      end
    end
    #1;
    pm = 0;
    for (int p = 0; p < 2; p++) if (m_full[p]) pm[m_addr[p]] = 1'b1;
    if (m_we) pm[m_wa] = 1'b1;
    pm[0] = 1'b0;
    chk("rf_we", rf_we, m_we);
    chk("rf_wa", rf_wa, m_wa);
    chk("rf_wd", rf_wd, m_wd);
    chk("pend_mask", pend_mask, pm);
    if (rf_we === 1'b1) shadow[rf_wa] = rf_wd;
  endtask

  task automatic req(input int p, input logic v, input logic [4:0] a, input logic [31:0] d);
    if (p == 0) begin p0_valid = v; p0_addr = a; p0_data = d; end
    else        begin p1_valid = v; p1_addr = a; p1_data = d; end
  endtask

  task automatic idle(input int n);
    req(0, 0, 0, 0);
    req(1, 0, 0, 0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  int wcnt;

  initial begin
    for (int i = 0; i < 32; i++) shadow[i] = 0;
    m_full[0] = 0; m_full[1] = 0; m_we = 0; m_wa = 0; m_wd = 0; m_last = 0;
    rst = 1;
    req(0, 0, 0, 0);
    req(1, 0, 0, 0);
    cycle();
    cycle();
    rst = 0;
    idle(1);

    // single write
    req(0, 1, 5, 32'hDEADBEEF);
    cycle();
    chk("single_acc", acc0, 1);
    chk("single_pend5", pend_mask[5], 1);
    idle(3);
    chk("single_rf5", shadow[5], 32'hDEADBEEF);

    // address 0 is swallowed
    req(1, 1, 0, 32'h1234);
    cycle();
    chk("a0_acc", acc1, 1);
    idle(3);

    // different-address conflict, both ports busy for 4 cycles
    req(0, 1, 1, 32'h100);
    req(1, 1, 2, 32'h200);
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (acc0) req(0, 1, 5'(1 + 2 * (i + 1) % 14), 32'h100 + i);
      if (acc1) req(1, 1, 5'(2 + 2 * (i + 1) % 14), 32'h200 + i);
    end
    idle(4);

    // same-address, same-edge accept: port 1 value ends in the register file
    req(0, 1, 7, 32'hA);
    req(1, 1, 7, 32'hB);
    cycle();
    idle(4);
    chk("same_rf7", shadow[7], 32'hB);

    // back-to-back port 0 stream
    wcnt = 0;
    for (int i = 0; i < 8; i++) begin
      req(0, 1, 5'(8 + i), 32'hC000 + i);
      cycle();
      if (rf_we === 1'b1) wcnt++;
    end
    req(0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cycle();
      if (rf_we === 1'b1) wcnt++;
    end
    chk("stream_writes", wcnt, 8);
    chk("stream_last", shadow[15], 32'hC007);

    // reset mid-stream with both buffers full
    req(0, 1, 3, 32'h33);
    req(1, 1, 4, 32'h44);
    cycle();
    req(0, 1, 9, 32'h99);
    req(1, 1, 10, 32'hAA);
    rst = 1;
    cycle();
    chk("rst_we", rf_we, 0);
    chk("rst_pend", pend_mask, 0);
    rst = 0;
    idle(3);

    // randomized traffic, requests held until accepted
    for (int i = 0; i < 600; i++) begin
      if (i == 0 || acc0 || !p0_valid)
        req(0, ($urandom % 4) != 0, 5'($urandom_range(0, 7)), $urandom);
      if (i == 0 || acc1 || !p1_valid)
        req(1, ($urandom % 4) != 0, 5'($urandom_range(0, 7)), $urandom);
      if (i == 300) rst = 1;
      if (i == 301) rst = 0;
      cycle();
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
